// File: rtl/spi_flash_reader_if.sv
// spi_flash_reader_if: CPU peripheral bus plus SPI master register port of the
// flash read engine. The slave modport is the engine's view; the master
// modport is the environment's view, which plays both the CPU and the SPI master.
interface spi_flash_reader_if;
  // CPU peripheral bus
  logic [31:0] data_i;
  logic [31:0] addr_i;
  logic        we_i;
  logic        req_i;
  logic [31:0] data_o;
  logic        ack_o;
  // SPI master register port
  logic [31:0] m_data_o;
  logic [31:0] m_addr_o;
  logic        m_we_o;
  logic        m_req_o;
  logic [31:0] m_data_i;

  modport slave (
    input  data_i, addr_i, we_i, req_i, m_data_i,
    output data_o, ack_o, m_data_o, m_addr_o, m_we_o, m_req_o
  );

  modport master (
    output data_i, addr_i, we_i, req_i, m_data_i,
    input  data_o, ack_o, m_data_o, m_addr_o, m_we_o, m_req_o
  );
endinterface

// File: rtl/spi_flash_reader.sv
// spi_flash_reader: reads LEN (1..16) bytes from SPI flash at ADDR by driving
// the SPI master register port (command, 24-bit address, dummy bytes) and
// collects the returned bytes in a 16-byte buffer readable by the CPU.
// Optional feature: define SPI_FLASH_FAST_READ_EN to implement CTRL[4]
// (fast read, command 0x0B followed by one uncaptured dummy byte).
module spi_flash_reader #(
  parameter int TIMEOUT_W = 16
) (
  input logic               clk,
  input logic               rst,
  spi_flash_reader_if.slave bus
);
  typedef enum logic [2:0] {
    IDLE, WR_DATA, WR_CTRL, WAIT_BUSY, WAIT_IDLE, RD_DATA, DESEL
  } state_t;

  // The counter is bumped on the cycle that decides, so it lands on
  // all-ones exactly as the FSM leaves for DESEL.
  localparam logic [TIMEOUT_W-1:0] WDOG_LAST = ~TIMEOUT_W'(1);

  state_t               state, state_nx;
  logic [4:0]           idx, idx_nx;
  logic [TIMEOUT_W-1:0] wdog;
  logic                 cpol, cpha, fast;
  logic [7:0]           div;
  logic [23:0]          flash_addr;
  logic [4:0]           len;
  logic                 busy, done, err;
  logic [7:0]           rd_buf [16];

  logic        reg_wr, wr_ctrl, wr_addr, wr_len, start, len_ok;
  logic        last, wdog_top, timeout;
  logic [4:0]  hdr, buf_idx;
  logic [7:0]  tx_byte;
  logic [31:0] m_data_nx, m_addr_nx;
  logic        m_we_nx;
  logic [1:0]  rd_word;

  // Configuration registers only accept writes while no transfer runs.
  assign reg_wr   = bus.req_i & bus.we_i & ~busy;
  assign wr_ctrl  = reg_wr && (bus.addr_i[4:0] == 5'h00);
  assign wr_addr  = reg_wr && (bus.addr_i[4:0] == 5'h04);
  assign wr_len   = reg_wr && (bus.addr_i[4:0] == 5'h08);
  assign start    = wr_ctrl & bus.data_i[0];
  assign len_ok   = (len != 5'd0) && (len <= 5'd16);
  assign hdr      = fast ? 5'd5 : 5'd4;
  assign last     = (idx == hdr + len - 5'd1);
  assign buf_idx  = idx - hdr;
  assign wdog_top = (wdog == WDOG_LAST);
  assign rd_word  = bus.addr_i[3:2];

`ifndef SPI_FLASH_FAST_READ_EN
  assign fast = 1'b0;
`endif

  // Next state, byte index and the SPI-port values for the state being entered.
  always_comb begin
    // NOTE: every variable gets a default first, so no path leaves one unassigned and no latch is inferred.
    state_nx  = state;
    idx_nx    = idx;
    timeout   = 1'b0;
    tx_byte   = 8'h00;
    m_addr_nx = 32'h0;
    m_data_nx = 32'h0;
    m_we_nx   = 1'b0;
    case (state)
      IDLE:      if (start && len_ok) begin
                   state_nx = WR_DATA;
                   idx_nx   = 5'd0;
                 end
      WR_DATA:   state_nx = WR_CTRL;
      WR_CTRL:   state_nx = WAIT_BUSY;
      WAIT_BUSY: if (bus.m_data_i[0]) state_nx = WAIT_IDLE;
                 else if (wdog_top) begin
                   state_nx = DESEL;
                   timeout  = 1'b1;
                 end
      WAIT_IDLE: if (!bus.m_data_i[0]) state_nx = RD_DATA;
                 else if (wdog_top) begin
                   state_nx = DESEL;
                   timeout  = 1'b1;
                 end
      RD_DATA:   if (last) state_nx = DESEL;
                 else begin
                   state_nx = WR_DATA;
                   idx_nx   = idx + 5'd1;
                 end
      DESEL:     state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase

    case (idx_nx)
      5'd0:    tx_byte = fast ? 8'h0B : 8'h03;
      5'd1:    tx_byte = flash_addr[23:16];
      5'd2:    tx_byte = flash_addr[15:8];
      5'd3:    tx_byte = flash_addr[7:0];
      default: tx_byte = 8'h00;
    endcase

    case (state_nx)
      WR_DATA:   begin m_addr_nx = 32'h4; m_we_nx = 1'b1; m_data_nx = {24'h0, tx_byte}; end
      WR_CTRL:   begin m_addr_nx = 32'h0; m_we_nx = 1'b1;
                       m_data_nx = {16'h0, div, 4'h0, 1'b1, cpha, cpol, 1'b1}; end
      WAIT_BUSY,
      WAIT_IDLE: m_addr_nx = 32'h8;
      RD_DATA:   m_addr_nx = 32'h4;
      DESEL:     begin m_addr_nx = 32'h0; m_we_nx = 1'b1;
                       m_data_nx = {16'h0, div, 4'h0, 1'b0, cpha, cpol, 1'b0}; end
      default:   ;
    endcase
  end

  // FSM state, byte index, watchdog and registered SPI-port outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      idx          <= 5'd0;
      wdog         <= '0;
      bus.m_addr_o <= 32'h0;
      bus.m_data_o <= 32'h0;
      bus.m_we_o   <= 1'b0;
      bus.m_req_o  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every flop here sample pre-edge values, independent of statement order.
      state        <= state_nx;
      idx          <= idx_nx;
      bus.m_addr_o <= m_addr_nx;
      bus.m_data_o <= m_data_nx;
      bus.m_we_o   <= m_we_nx;
      bus.m_req_o  <= (state_nx != IDLE);
      if (state_nx == WR_DATA)
        wdog <= '0;
      else if (state == WAIT_BUSY || state == WAIT_IDLE)
        wdog <= wdog + TIMEOUT_W'(1);
    end
  end

  // CPU-writable configuration: CTRL fields, flash address, byte count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cpol       <= 1'b0;
      cpha       <= 1'b0;
      div        <= 8'h00;
      flash_addr <= 24'h0;
      len        <= 5'd0;
`ifdef SPI_FLASH_FAST_READ_EN
      fast       <= 1'b0;
`endif
    end else begin
      if (wr_ctrl) begin
        cpol <= bus.data_i[1];
        cpha <= bus.data_i[2];
        div  <= bus.data_i[15:8];
`ifdef SPI_FLASH_FAST_READ_EN
        fast <= bus.data_i[4];
`endif
      end
      if (wr_addr) flash_addr <= bus.data_i[23:0];
      if (wr_len)  len        <= bus.data_i[4:0];
    end
  end

  // Status flags: a start clears done/err; a bad length only flags err.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy <= 1'b0;
      done <= 1'b0;
      err  <= 1'b0;
    end else begin
      if (start) begin
        busy <= len_ok;
        done <= 1'b0;
        err  <= ~len_ok;
      end
      if (timeout) err <= 1'b1;
      if (state == DESEL) begin
        busy <= 1'b0;
        done <= 1'b1;
      end
    end
  end

  // Bus acknowledge, one cycle after every request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) bus.ack_o <= 1'b0;
    else      bus.ack_o <= bus.req_i;
  end

  // Capture data-phase bytes; bytes past LEN keep their old contents.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the buffer is tiny and must read as zero after reset, so it is built from resettable flops, not RAM.
      for (int i = 0; i < 16; i++) rd_buf[i] <= 8'h00;
    end else if (state == RD_DATA && idx >= hdr) begin
      rd_buf[buf_idx[3:0]] <= bus.m_data_i[7:0];
    end
  end

  // CPU read decode, combinational on addr_i.
  always_comb begin
    bus.data_o = 32'h0;
    case (bus.addr_i[4:0])
      5'h00: bus.data_o = {16'h0, div, 3'b000, fast, 1'b0, cpha, cpol, 1'b0};
      5'h04: bus.data_o = {8'h00, flash_addr};
      5'h08: bus.data_o = {27'h0, len};
      5'h0C: bus.data_o = {29'h0, err, done, busy};
      5'h10, 5'h14, 5'h18, 5'h1C:
        bus.data_o = {rd_buf[{rd_word, 2'd3}], rd_buf[{rd_word, 2'd2}],
                      rd_buf[{rd_word, 2'd1}], rd_buf[{rd_word, 2'd0}]};
      default: bus.data_o = 32'h0;
    endcase
  end

  // Bits the engine never decodes, gathered so they are visibly ignored.
  logic unused_bits;
  assign unused_bits = ^{bus.data_i[31:24], bus.addr_i[31:5], bus.m_data_i[31:8]};
endmodule
